// File: rtl/xbar_sched_if.sv
// xbar_sched_if: source/destination bundle for the round-robin scheduled crossbar.
//   slave  modport : scheduler side (takes source elements, presents destination registers)
//   master modport : producer/consumer side
// Signals:
//   src_valid_i [NumElem]            source s has an element
//   src_dst_i   [NumElem][IdxW]      destination index for source s
//   src_data_i  [NumElem][ElemWidth] element of source s
//   src_ready_o [NumElem]            source s element accepted this cycle
//   dst_valid_o [NumElem]            destination d register holds an element
//   dst_data_o  [NumElem][ElemWidth] element held for destination d
//   dst_src_o   [NumElem][IdxW]      source index that produced dst_data_o[d]
//   dst_ready_i [NumElem]            destination d consumes element
//   err_o                            pulse: out-of-range destination dropped last cycle
interface xbar_sched_if #(
  parameter int unsigned ElemWidth = 4,
  parameter int unsigned NumElem   = 5
);
  localparam int unsigned IdxW = $clog2(NumElem);

  logic [NumElem-1:0]                src_valid_i;
  logic [NumElem-1:0][IdxW-1:0]      src_dst_i;
  logic [NumElem-1:0][ElemWidth-1:0] src_data_i;
  logic [NumElem-1:0]                src_ready_o;
  logic [NumElem-1:0]                dst_valid_o;
  logic [NumElem-1:0][ElemWidth-1:0] dst_data_o;
  logic [NumElem-1:0][IdxW-1:0]      dst_src_o;
  logic [NumElem-1:0]                dst_ready_i;
  logic                              err_o;

  modport slave (
    input  src_valid_i, src_dst_i, src_data_i, dst_ready_i,
    output src_ready_o, dst_valid_o, dst_data_o, dst_src_o, err_o
  );

  modport master (
    output src_valid_i, src_dst_i, src_data_i, dst_ready_i,
    input  src_ready_o, dst_valid_o, dst_data_o, dst_src_o, err_o
  );
endinterface

// File: rtl/xbar_sched.sv
// xbar: purely combinational crossbar, lane d outputs i_data[i_sel[d]].
//   i_data [NumElem][ElemWidth]  source elements
//   i_sel  [NumElem][IdxW]       per-lane source select
//   o_data [NumElem][ElemWidth]  per-lane selected element
module xbar #(
  parameter int unsigned ElemWidth = 4,
  parameter int unsigned NumElem   = 5,
  parameter int unsigned IdxW      = 3
) (
  input  logic [NumElem-1:0][ElemWidth-1:0] i_data,
  input  logic [NumElem-1:0][IdxW-1:0]      i_sel,
  output logic [NumElem-1:0][ElemWidth-1:0] o_data
);
  always_comb begin
    o_data = '0;
    for (int unsigned d = 0; d < NumElem; d++) begin
      o_data[d] = i_data[i_sel[d]];
    end
  end
endmodule

// xbar_sched: round-robin scheduled crossbar switch.
// Each destination runs its own round-robin arbiter over the sources that
// target it; the winner drives the xbar select for that lane and is captured
// into the destination output register when the slot is free.
// Ports:
//   clk_i    clock, all state on rising edge
//   arst_ni  asynchronous active-low reset
//   bus      xbar_sched_if.slave (source/destination handshakes, err_o)
module xbar_sched #(
  parameter int unsigned ElemWidth = 4,
  parameter int unsigned NumElem   = 5
) (
  input  logic          clk_i,
  input  logic          arst_ni,
  xbar_sched_if.slave   bus
);
  localparam int unsigned IdxW = $clog2(NumElem);

  // state
  logic [NumElem-1:0]                r_valid;
  logic [NumElem-1:0][ElemWidth-1:0] r_data;
  logic [NumElem-1:0][IdxW-1:0]      r_src;
  logic [NumElem-1:0][IdxW-1:0]      r_ptr;
  logic                              r_err;

  // arbitration
  logic [NumElem-1:0][NumElem-1:0]   w_req;      // [dst][src]
  logic [NumElem-1:0]                w_oor;
  logic [NumElem-1:0]                w_win_vld;
  logic [NumElem-1:0][IdxW-1:0]      w_win;
  logic [NumElem-1:0]                w_slot_free;
  logic [NumElem-1:0]                w_gnt;
  logic [NumElem-1:0][IdxW-1:0]      w_ptr_nxt;
  logic [NumElem-1:0]                w_src_rdy;
  logic [NumElem-1:0][ElemWidth-1:0] w_xbar_data;

  // Request matrix and out-of-range detection.
  always_comb begin
    w_req = '0;
    w_oor = '0;
    for (int unsigned s = 0; s < NumElem; s++) begin
      w_oor[s] = bus.src_valid_i[s] && (32'(bus.src_dst_i[s]) >= NumElem);
      for (int unsigned d = 0; d < NumElem; d++) begin
        w_req[d][s] = bus.src_valid_i[s] && (bus.src_dst_i[s] == IdxW'(d));
      end
    end
  end

  // Per-destination round robin: scan ptr, ptr+1, ... modulo NumElem and
  // take the first requester. Index is wrapped by subtraction so NumElem
  // need not be a power of two.
  always_comb begin : arb
    int unsigned     sum;
    logic [IdxW-1:0] v_idx;
    sum       = 0;
    v_idx     = '0;
    w_win_vld = '0;
    w_win     = '0;
    for (int unsigned d = 0; d < NumElem; d++) begin
      for (int unsigned k = 0; k < NumElem; k++) begin
        sum = 32'(r_ptr[d]) + k;
        if (sum >= NumElem) sum = sum - NumElem;
        v_idx = IdxW'(sum);
        if (!w_win_vld[d] && w_req[d][v_idx]) begin
          w_win_vld[d] = 1'b1;
          w_win[d]     = v_idx;
        end
      end
    end
  end

  // Slot is free when empty or being drained this cycle (pass-through).
  assign w_slot_free = ~r_valid | bus.dst_ready_i;
  assign w_gnt       = w_win_vld & w_slot_free;

  always_comb begin
    w_ptr_nxt = r_ptr;
    for (int unsigned d = 0; d < NumElem; d++) begin
      if (w_gnt[d]) begin
        if (32'(w_win[d]) == NumElem - 1) w_ptr_nxt[d] = '0;
        else                              w_ptr_nxt[d] = w_win[d] + IdxW'(1);
      end
    end
  end

  // A source is ready when it won a free slot, or when its destination is
  // out of range (element is dropped immediately).
  always_comb begin
    w_src_rdy = '0;
    for (int unsigned d = 0; d < NumElem; d++) begin
      if (w_gnt[d]) w_src_rdy[w_win[d]] = 1'b1;
    end
    for (int unsigned s = 0; s < NumElem; s++) begin
      if (w_oor[s]) w_src_rdy[s] = 1'b1;
    end
  end

  xbar #(
    .ElemWidth (ElemWidth),
    .NumElem   (NumElem),
    .IdxW      (IdxW)
  ) u_xbar (
    .i_data (bus.src_data_i),
    .i_sel  (w_win),
    .o_data (w_xbar_data)
  );

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_valid <= '0;
      r_data  <= '0;
      r_src   <= '0;
      r_ptr   <= '0;
      r_err   <= 1'b0;
    end else begin
      for (int unsigned d = 0; d < NumElem; d++) begin
        if (w_gnt[d]) begin
          r_valid[d] <= 1'b1;
          r_data[d]  <= w_xbar_data[d];
          r_src[d]   <= w_win[d];
        end else if (bus.dst_ready_i[d]) begin
          r_valid[d] <= 1'b0;
        end
      end
      r_ptr <= w_ptr_nxt;
      r_err <= |w_oor;
    end
  end

  // Ready is combinational; hold it low while reset is asserted.
  assign bus.src_ready_o = arst_ni ? w_src_rdy : '0;
  assign bus.dst_valid_o = r_valid;
  assign bus.dst_data_o  = r_data;
  assign bus.dst_src_o   = r_src;
  assign bus.err_o       = r_err;
endmodule
